// File: rtl/chacha_keystream_serializer.sv
// rtl/chacha_keystream_serializer.sv - ChaCha block adder and keystream chunk serializer
//
// Adds the core's initial state and post-round state word-wise (mod 2^WORD_BITS)
// and streams the keystream as OUT_BITS chunks over a valid/ready interface.
// Back-to-back blocks are accepted on the final chunk's transfer, so a stream of
// blocks runs without bubbles.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous reset, active-low
//   flush_i          synchronous abort of the block in flight
//   in_valid_i       block pair valid
//   in_ready_o       block pair accepted when in_valid_i && in_ready_o
//   initial_block_i  initial state, word i at [i*WORD_BITS +: WORD_BITS]
//   final_block_i    post-round state, same layout
//   ks_valid_o       keystream chunk valid
//   ks_ready_i       downstream ready
//   ks_data_o        keystream chunk
//   ks_last_o        final chunk of a block
//   busy_o           a block is held
module chacha_keystream_serializer #(
  parameter int WORDS         = 16,
  parameter int WORD_BITS     = 32,
  parameter int OUT_BITS      = 8,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WORDS*WORD_BITS-1:0] initial_block_i,
  input  logic [WORDS*WORD_BITS-1:0] final_block_i,
  output logic                       ks_valid_o,
  input  logic                       ks_ready_i,
  output logic [OUT_BITS-1:0]        ks_data_o,
  output logic                       ks_last_o,
  output logic                       busy_o
);

  localparam int BLOCK_BITS = WORDS * WORD_BITS;
  localparam int CHUNKS     = WORD_BITS / OUT_BITS;
  localparam int CW         = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int WW         = $clog2(WORDS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]            state_q;
  logic [BLOCK_BITS-1:0] init_q;
  logic [BLOCK_BITS-1:0] final_q;
  logic [WORD_BITS-1:0]  word_q;
  logic [WW-1:0]         word_cnt_q;
  logic [CW-1:0]         chunk_cnt_q;

  logic                  emit;
  logic                  last_chunk;
  logic                  last_word;
  logic                  xfer;
  logic                  accept;
  logic [WORD_BITS-1:0]  first_sum;
  logic [WORD_BITS-1:0]  next_sum;
  logic [WORD_BITS-1:0]  chunk_sh;
  logic [BLOCK_BITS-1:0] init_sh;
  logic [BLOCK_BITS-1:0] final_sh;
  logic [31:0]           next_idx;
  logic [31:0]           chunk_idx;

  assign emit       = (state_q == S_EMIT);
  assign last_chunk = (chunk_cnt_q == CW'(CHUNKS - 1));
  assign last_word  = (word_cnt_q == WW'(WORDS - 1));

  assign ks_valid_o = emit;
  assign busy_o     = emit;
  assign ks_last_o  = emit && last_word && last_chunk;
  assign xfer       = emit && ks_ready_i;

  // Ready in IDLE, or on the transfer of a block's final chunk so the next
  // block follows without a gap. Flush always blocks acceptance.
  assign in_ready_o = !flush_i && (!emit || (ks_ready_i && last_word && last_chunk));
  assign accept     = in_valid_i && in_ready_o;

  // Word 0 is summed straight from the inputs so the first chunk is ready one
  // cycle after the accept edge.
  assign first_sum = initial_block_i[WORD_BITS-1:0] + final_block_i[WORD_BITS-1:0];

  always_comb begin
    next_idx  = 32'(word_cnt_q) + 32'd1;
    init_sh   = init_q >> (next_idx * WORD_BITS);
    final_sh  = final_q >> (next_idx * WORD_BITS);
    next_sum  = init_sh[WORD_BITS-1:0] + final_sh[WORD_BITS-1:0];
    chunk_idx = LITTLE_ENDIAN ? 32'(chunk_cnt_q) : (32'(CHUNKS - 1) - 32'(chunk_cnt_q));
    chunk_sh  = word_q >> (chunk_idx * OUT_BITS);
  end

  assign ks_data_o = emit ? chunk_sh[OUT_BITS-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      init_q      <= '0;
      final_q     <= '0;
      word_q      <= '0;
      word_cnt_q  <= '0;
      chunk_cnt_q <= '0;
    end else if (flush_i) begin
      // A chunk handshaking in this cycle is treated as delivered; the rest
      // of the block is dropped.
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      chunk_cnt_q <= '0;
    end else if (accept) begin
      state_q     <= S_EMIT;
      init_q      <= initial_block_i;
      final_q     <= final_block_i;
      word_q      <= first_sum;
      word_cnt_q  <= '0;
      chunk_cnt_q <= '0;
    end else if (xfer) begin
      if (!last_chunk) begin
        chunk_cnt_q <= chunk_cnt_q + CW'(1);
      end else if (!last_word) begin
        chunk_cnt_q <= '0;
        word_cnt_q  <= word_cnt_q + WW'(1);
        word_q      <= next_sum;
      end else begin
        state_q     <= S_IDLE;
        word_cnt_q  <= '0;
        chunk_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_chacha_keystream_serializer.sv
// tb/tb_chacha_keystream_serializer.sv - self-checking bench for chacha_keystream_serializer
`timescale 1ns/1ps
module tb_chacha_keystream_serializer;

  localparam int WORDS = 16;
  localparam int WB    = 32;
  localparam int BW    = WORDS * WB;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [BW-1:0] ini;
    logic [BW-1:0] fin;
    int            pct;
    logic [127:0]  le16;
    logic [127:0]  be16;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, ks_ready;
  logic [BW-1:0] ini, fin;
  logic          in_ready, ks_valid, ks_last, busy;
  logic [7:0]    ks_data;
  logic          in_ready_be, ks_valid_be, ks_last_be, busy_be;
  logic [7:0]    ks_data_be;
  logic          in_ready_w, ks_valid_w, ks_last_w, busy_w;
  logic [31:0]   ks_data_w;
  logic          in_valid_g;

  // Secondary instances only take a block when the main instance does.
  assign in_valid_g = in_valid && in_ready;

  chacha_keystream_serializer #(.WORDS(16), .WORD_BITS(32), .OUT_BITS(8), .LITTLE_ENDIAN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .initial_block_i(ini), .final_block_i(fin), .ks_valid_o(ks_valid), .ks_ready_i(ks_ready),
    .ks_data_o(ks_data), .ks_last_o(ks_last), .busy_o(busy));

  chacha_keystream_serializer #(.WORDS(16), .WORD_BITS(32), .OUT_BITS(8), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid_g), .in_ready_o(in_ready_be),
    .initial_block_i(ini), .final_block_i(fin), .ks_valid_o(ks_valid_be), .ks_ready_i(ks_ready),
    .ks_data_o(ks_data_be), .ks_last_o(ks_last_be), .busy_o(busy_be));

  chacha_keystream_serializer #(.WORDS(16), .WORD_BITS(32), .OUT_BITS(32), .LITTLE_ENDIAN(1'b1)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid_g), .in_ready_o(in_ready_w),
    .initial_block_i(ini), .final_block_i(fin), .ks_valid_o(ks_valid_w), .ks_ready_i(ks_ready),
    .ks_data_o(ks_data_w), .ks_last_o(ks_last_w), .busy_o(busy_w));

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  exp_t q_le[$], q_be[$], q_w[$];
  logic [31:0] rx_le[$], rx_be[$], rx_w[$];
  logic prev_acc = 0, prev_flush = 0, prev_stall = 0, prev_last = 0;
  logic [7:0] prev_data = '0;
  logic b2b_on = 0;
  int b2b_cyc = 0, b2b_valid = 0;
  int ir_hits[$];

  logic [31:0] rfc_i [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  logic [31:0] rfc_f [16] = '{32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
                              32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
                              32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
                              32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
  logic [BW-1:0] rfc_ini, rfc_fin, cy_ini, cy_fin;
  vec_t vecs[3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=missing exp=present", name);
  endtask

  task automatic push_block(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [31:0] s;
    for (int i = 0; i < WORDS; i++) begin
      s = a[i*WB +: WB] + b[i*WB +: WB];
      for (int k = 0; k < 4; k++) begin
        q_le.push_back('{32'(s[8*k +: 8]), (i == WORDS-1) && (k == 3)});
        q_be.push_back('{32'(s[8*(3-k) +: 8]), (i == WORDS-1) && (k == 3)});
      end
      q_w.push_back('{s, i == WORDS-1});
    end
  endtask

  task automatic clear_all();
    q_le.delete(); q_be.delete(); q_w.delete();
  endtask

  task automatic clear_rx();
    rx_le.delete(); rx_be.delete(); rx_w.delete();
  endtask

  // One clock: sample at the falling edge, return 1ns after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_valid", 128'(ks_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
    end else begin
      if (prev_acc) check("latency_valid", 128'(ks_valid), 128'(1));
      if (prev_flush) begin
        check("flush_valid", 128'(ks_valid), 128'(0));
        check("flush_busy", 128'(busy), 128'(0));
      end
      if (flush) check("flush_in_ready", 128'(in_ready), 128'(0));
      if (prev_stall) begin
        check("stall_data", 128'(ks_data), 128'(prev_data));
        check("stall_last", 128'(ks_last), 128'(prev_last));
      end
      if (ks_valid && ks_ready) begin
        rx_le.push_back(32'(ks_data));
        if (q_le.size() == 0) fail_now("le_expected_entry");
        else begin
          e = q_le.pop_front();
          check("le_data", 128'(ks_data), 128'(e.data));
          check("le_last", 128'(ks_last), 128'(e.last));
        end
      end
      if (ks_valid_be && ks_ready) begin
        rx_be.push_back(32'(ks_data_be));
        if (q_be.size() == 0) fail_now("be_expected_entry");
        else begin
          e = q_be.pop_front();
          check("be_data", 128'(ks_data_be), 128'(e.data));
          check("be_last", 128'(ks_last_be), 128'(e.last));
        end
      end
      if (ks_valid_w && ks_ready) begin
        rx_w.push_back(ks_data_w);
        if (q_w.size() == 0) fail_now("w_expected_entry");
        else begin
          e = q_w.pop_front();
          check("w_data", 128'(ks_data_w), 128'(e.data));
          check("w_last", 128'(ks_last_w), 128'(e.last));
        end
      end
      if (b2b_on) begin
        if (b2b_cyc < 128 && in_ready) ir_hits.push_back(b2b_cyc);
        if (b2b_cyc >= 1 && b2b_cyc <= 128 && ks_valid) b2b_valid++;
        b2b_cyc++;
      end
    end
    prev_acc   = rst_n && in_valid && in_ready;
    if (prev_acc) begin
      acc_cnt++;
      push_block(ini, fin);
    end
    prev_flush = rst_n && flush;
    prev_stall = rst_n && ks_valid && !ks_ready;
    prev_data  = ks_data;
    prev_last  = ks_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int n;
    n = acc_cnt;
    ini = a; fin = b; in_valid = 1'b1;
    for (int t = 0; t < 200 && acc_cnt == n; t++) tick();
    in_valid = 1'b0;
    if (acc_cnt == n) fail_now("send_accept");
  endtask

  task automatic drain(input int pct);
    int t;
    t = 0;
    while ((q_le.size() != 0 || q_be.size() != 0 || q_w.size() != 0 || ks_valid) && t < 2000) begin
      ks_ready = ($urandom_range(0, 99) < pct);
      tick();
      t++;
    end
    ks_ready = 1'b1;
    if (t >= 2000) fail_now("drain_done");
  endtask

  function automatic logic [127:0] first16(input logic [31:0] rx [$]);
    logic [127:0] g;
    g = '0;
    for (int j = 0; j < 16; j++) g = {g[119:0], (j < rx.size()) ? rx[j][7:0] : 8'hxx};
    return g;
  endfunction

  function automatic logic [127:0] first4w(input logic [31:0] rx [$]);
    logic [127:0] g;
    g = '0;
    for (int j = 0; j < 4; j++) g = {g[95:0], (j < rx.size()) ? rx[j] : 32'hxxxxxxxx};
    return g;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < WORDS; i++) begin
      rfc_ini[i*WB +: WB] = rfc_i[i];
      rfc_fin[i*WB +: WB] = rfc_f[i];
      cy_ini[i*WB +: WB]  = 32'hffffffff;
      cy_fin[i*WB +: WB]  = 32'(i + 1);
    end
    vecs[0] = '{rfc_ini, rfc_fin, 100, 128'h10f1e7e4_d13b5915_500fdd1f_a32071c4,
                128'he4e7f110_15593bd1_1fdd0f50_c47120a3};
    vecs[1] = '{cy_ini, cy_fin, 100, 128'h00000000_01000000_02000000_03000000,
                128'h00000000_00000001_00000002_00000003};
    vecs[2] = '{cy_ini, cy_fin, 50, 128'h00000000_01000000_02000000_03000000,
                128'h00000000_00000001_00000002_00000003};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ks_ready = 1'b1; ini = '0; fin = '0;
    repeat (3) tick();
    check("rst_last", 128'(ks_last), 128'(0));
    check("rst_data", 128'(ks_data), 128'(0));
    check("rst_data_be", 128'(ks_data_be), 128'(0));
    check("rst_data_w", 128'(ks_data_w), 128'(0));
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 3; v++) begin
      clear_rx();
      send(vecs[v].ini, vecs[v].fin);
      drain(vecs[v].pct);
      check("vec_le16", first16(rx_le), vecs[v].le16);
      check("vec_be16", first16(rx_be), vecs[v].be16);
      check("vec_w4", first4w(rx_w), vecs[v].be16);
      check("vec_le_count", 128'(rx_le.size()), 128'(64));
      check("vec_w_count", 128'(rx_w.size()), 128'(16));
    end

    // Two blocks back to back with in_valid held high.
    clear_rx();
    ir_hits.delete();
    b2b_on = 1'b1; b2b_cyc = 0; b2b_valid = 0;
    n = acc_cnt;
    ini = rfc_ini; fin = rfc_fin; in_valid = 1'b1;
    for (int t = 0; t < 200 && acc_cnt == n; t++) tick();
    ini = cy_ini; fin = cy_fin;
    for (int t = 0; t < 200 && acc_cnt < n + 2; t++) tick();
    in_valid = 1'b0;
    if (acc_cnt != n + 2) fail_now("b2b_accepts");
    drain(100);
    b2b_on = 1'b0;
    check("b2b_valid_cycles", 128'(b2b_valid), 128'(128));
    check("b2b_ready_pulses", 128'(ir_hits.size()), 128'(2));
    if (ir_hits.size() == 2) begin
      check("b2b_ready_cyc0", 128'(ir_hits[0]), 128'(0));
      check("b2b_ready_cyc1", 128'(ir_hits[1]), 128'(64));
    end
    check("b2b_bytes", 128'(rx_le.size()), 128'(128));

    // Flush while byte 20 is handshaking, with a competing in_valid.
    clear_rx();
    send(rfc_ini, rfc_fin);
    for (int t = 0; t < 200 && rx_le.size() < 20; t++) tick();
    flush = 1'b1; in_valid = 1'b1; ini = cy_ini; fin = cy_fin;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    clear_all();
    tick();
    check("flush_bytes_delivered", 128'(rx_le.size()), 128'(21));
    check("flush_no_accept", 128'(busy), 128'(0));

    // Asynchronous reset at byte 10 of a new block.
    clear_rx();
    send(cy_ini, cy_fin);
    for (int t = 0; t < 200 && rx_le.size() < 10; t++) tick();
    rst_n = 1'b0;
    clear_all();
    #1;
    check("async_rst_valid", 128'(ks_valid), 128'(0));
    check("async_rst_busy_w", 128'(busy_w), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    clear_rx();
    send(rfc_ini, rfc_fin);
    drain(100);
    check("restart_le16", first16(rx_le), vecs[0].le16);
    check("restart_be16", first16(rx_be), vecs[0].be16);
    check("restart_count", 128'(rx_le.size()), 128'(64));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
